// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_write_arbiter
// Description : Round-robin arbiter that shares the write port of a register
//               bank between NUM_REQ requesters. The winning write is
//               registered for one cycle, then presented as a one-hot write
//               enable plus shared write data.
// Ports       : clk        - clock, all state on the rising edge
//               reset_n    - asynchronous active-low reset
//               hold       - 1 = issue no new grants this cycle
//               req_valid  - per-requester write request
//               req_addr   - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//               req_data   - packed data, requester i at [i*WIDTH +: WIDTH]
//               req_ready  - one-hot grant (combinational)
//               reg_we     - one-hot register write enable
//               reg_wdata  - register write data
//               grant_id   - requester index of the write on reg_we / addr_err
//               addr_err   - pulse: granted address out of range, write dropped
// Revision    : 1.0 - initial release
// ============================================================================
module register_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 4,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         hold,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REGS-1:0]          reg_we,
    output logic [WIDTH-1:0]             reg_wdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         addr_err
);

    localparam int                 c_ID_W = $clog2(NUM_REQ);
    localparam logic [c_ID_W-1:0]  c_LAST = c_ID_W'(NUM_REQ - 1);
    localparam logic [ADDR_W:0]    c_REGS = (ADDR_W + 1)'(NUM_REGS);

    logic [c_ID_W-1:0]   r_ptr;
    logic                w_found;
    logic [c_ID_W-1:0]   w_gnt_idx;
    logic [c_ID_W-1:0]   w_scan_id;
    int                  w_scan;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [WIDTH-1:0]    w_gnt_data;
    logic                w_addr_ok;
    logic [NUM_REGS-1:0] w_we_dec;
    logic [c_ID_W-1:0]   w_ptr_nxt;

    // Scan from the round-robin pointer upward, wrapping modulo NUM_REQ.
    // The modulo is done with an explicit subtract so a non-power-of-2
    // requester count still wraps correctly.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        w_scan_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_scan_id = c_ID_W'(w_scan);
            if (!w_found && req_valid[w_scan_id]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan_id;
            end
        end
    end

    // Gating with reset_n keeps every ready low while reset is asserted.
    assign w_grant = w_found & ~hold & reset_n;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_gnt_data = req_data[w_gnt_idx*WIDTH +: WIDTH];

    // Compare one bit wider so NUM_REGS equal to 2**ADDR_W stays representable.
    assign w_addr_ok  = ({1'b0, w_gnt_addr} < c_REGS);

    always_comb begin
        w_we_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_we_dec[r] = (w_gnt_addr == ADDR_W'(r));
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;

    // Pipeline stage: a grant in cycle N appears on the bank port in N+1.
    // Without a grant the enables drop while data and id hold their value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            reg_we    <= '0;
            reg_wdata <= '0;
            grant_id  <= '0;
            addr_err  <= 1'b0;
        end else if (w_grant) begin
            r_ptr     <= w_ptr_nxt;
            reg_we    <= w_addr_ok ? w_we_dec : '0;
            addr_err  <= ~w_addr_ok;
            reg_wdata <= w_gnt_data;
            grant_id  <= w_gnt_idx;
        end else begin
            reg_we    <= '0;
            addr_err  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_write_arbiter
// Description : Self-checking bench for register_write_arbiter with a
//               behavioural round-robin model and randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 6;
    localparam int WIDTH    = 4;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int ID_W     = $clog2(NUM_REQ);

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       hold = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
    logic [NUM_REQ*WIDTH-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REGS-1:0]        reg_we;
    logic [WIDTH-1:0]           reg_wdata;
    logic [ID_W-1:0]            grant_id;
    logic                       addr_err;

    register_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .grant_id  (grant_id),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_ptr, m_we, m_err, m_data, m_gid, last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_err = 0; m_data = 0; m_gid = 0; last_g = -1;
    endtask

    // Winner by the round-robin rule, -1 when nobody is granted.
    function automatic int model_grant();
        int idx;
        if (hold || !reset_n) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input int a, input int d);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        req_data[i*WIDTH +: WIDTH]   = WIDTH'(d);
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        int g, a;
        #1;
        g = model_grant();
        chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            a      = int'(req_addr[g*ADDR_W +: ADDR_W]);
            m_data = int'(req_data[g*WIDTH +: WIDTH]);
            m_gid  = g;
            m_err  = (a >= NUM_REGS) ? 1 : 0;
            m_we   = m_err ? 0 : (1 << a);
            m_ptr  = (g + 1) % NUM_REQ;
        end else begin
            m_we  = 0;
            m_err = 0;
        end
        last_g = g;
        chk("reg_we",    32'(reg_we),    m_we);
        chk("addr_err",  32'(addr_err),  m_err);
        chk("reg_wdata", 32'(reg_wdata), m_data);
        chk("grant_id",  32'(grant_id),  m_gid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Reset holds everything low even with all requesters valid
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  32'(req_ready), 0);
        chk("rst_we",     32'(reg_we),    0);
        chk("rst_err",    32'(addr_err),  0);
        chk("rst_wdata",  32'(reg_wdata), 0);
        chk("rst_gid",    32'(grant_id),  0);

        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i, 4'h3 + i);
        cycle();
        chk("first_grant", 32'(grant_id), 0);

        // Single write from requester 2
        req_valid = '0;
        set_req(2, 1'b1, 5, 4'hA);
        cycle();
        chk("single_we",    32'(reg_we),    32'h20);
        chk("single_wdata", 32'(reg_wdata), 32'hA);
        chk("single_gid",   32'(grant_id),  2);
        req_valid = '0;
        cycle();
        chk("single_we_off", 32'(reg_we), 0);

        // Bring pointer to 0, then all four valid for eight cycles
        set_req(3, 1'b1, 1, 4'h7);
        cycle();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i, 4'h8 + i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_gid", 32'(grant_id), k % NUM_REQ);
            chk("fair_we",  32'(reg_we),   1 << (k % NUM_REQ));
        end

        // Wrap/skip: pointer to 3, only req 1 valid, then reqs 0 and 3
        req_valid = '0;
        set_req(2, 1'b1, 2, 4'h1);
        cycle();
        req_valid = '0;
        set_req(1, 1'b1, 4, 4'h2);
        cycle();
        chk("skip_gid", 32'(grant_id), 1);
        req_valid = '0;
        set_req(0, 1'b1, 0, 4'h5);
        set_req(3, 1'b1, 3, 4'h6);
        cycle();
        chk("wrap_gid3", 32'(grant_id), 3);
        req_valid[3] = 1'b0;
        cycle();
        chk("wrap_gid0", 32'(grant_id), 0);

        // Out-of-range address
        req_valid = '0;
        set_req(1, 1'b1, 7, 4'hC);
        cycle();
        chk("oor_err", 32'(addr_err), 1);
        chk("oor_we",  32'(reg_we),   0);
        req_valid = '0;
        cycle();
        chk("oor_err_pulse", 32'(addr_err), 0);

        // hold after a grant: pending write still issues, no new ready
        set_req(2, 1'b1, 3, 4'h9);
        #1;
        hold = 1'b0;
        cycle();
        req_valid = '0;
        set_req(3, 1'b1, 2, 4'hE);
        hold = 1'b1;
        #1;
        chk("hold_ready", 32'(req_ready), 0);
        chk("hold_pending_we", 32'(reg_we), 32'h08);
        cycle();
        cycle();
        hold = 1'b0;
        cycle();
        chk("hold_release_gid", 32'(grant_id), 3);

        // Reset mid-stream with a write pending
        req_valid = '0;
        set_req(0, 1'b1, 4, 4'hB);
        cycle();
        req_valid = '0;
        set_req(1, 1'b1, 1, 4'h4);
        reset_n = 1'b0;
        #1;
        chk("midrst_we",    32'(reg_we),    0);
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_wdata", 32'(reg_wdata), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_valid = '0;

        // Randomized traffic obeying the requester rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || last_g == i)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                            $urandom_range(0, 15));
            end
            hold = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
